i2c_slave_regfile: RTL
======================

// Module: i2c_slave_regfile
// PURPOSE
//  Synthesisable, parametrised I2C target with an internal byte register file; next generation of the bench slave model.
//  Runs entirely in the clk domain: SCL/SDA are synchronised and oversampled, never used as clocks.
//  Adds multi-byte bursts with auto-increment, repeated START, address/range NACK and a local write-notify port.
//  Sits behind the I2C pads as the device-under-test partner for the AXI-I2C bridge and as a reusable peripheral.
// PARAMETERS
//  SLAVE_ADDR   7'h50  7-bit I2C device address matched in the address byte
//  NUM_REGS     16     register-file depth in bytes, 1..256; pointer is 8 bits
//  SYNC_STAGES  2      synchroniser flops on scl_i/sda_i, >=2
//  RESET_VAL    8'h00  reset value of every register
// PORTS
//  clk        in   1  system clock; must be >= 16x SCL frequency
//  rst        in   1  synchronous, active-high reset
//  scl_i      in   1  SCL pad input, asynchronous
//  sda_i      in   1  SDA pad input, asynchronous
//  sda_oe     out  1  1 = drive SDA low (open-drain); 0 = release
//  busy       out  1  1 from START address match until STOP or NACKed end of transfer
//  wr_stb     out  1  one-clk pulse per byte written into the register file
//  wr_addr    out  8  register index of the write signalled by wr_stb
//  wr_data    out  8  byte written, valid with wr_stb
// BEHAVIOUR
//  Reset: sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, pointer=0, state=IDLE, all registers=RESET_VAL.
//   Synchronisers load 1 (bus idle) so no false START follows reset. Reset mid-transfer aborts immediately and releases SDA.
//  Conditions (synchronised signals, evaluated every clk): START = SDA 1->0 while SCL=1; STOP = SDA 0->1 while SCL=1.
//   START in any state -> ADDR, bit counter=7 (repeated START). STOP in any state -> IDLE, busy=0, sda_oe=0.
//  Bits are sampled on the synchronised SCL rising edge; sda_oe changes only on the synchronised SCL falling edge.
//   sda_oe updates within SYNC_STAGES+2 clk of the pad SCL falling edge.
//  States:
//   IDLE      wait for START.
//   ADDR      shift 8 bits MSB first. Byte[7:1]==SLAVE_ADDR -> ADDR_ACK, latch rw=byte[0], busy=1.
//             Mismatch -> IGNORE (SDA released; waits for START/STOP).
//   ADDR_ACK  drive 0 for one SCL bit. Then rw=0 -> REG; rw=1 -> load shifter from regs[pointer], enter RDATA.
//   REG       shift 8 bits. Value < NUM_REGS -> pointer=value, REG_ACK. Out of range -> NACK (release SDA for the ACK bit), IGNORE.
//   REG_ACK   drive 0, then WDATA.
//   WDATA     shift 8 bits into regs[pointer]; wr_stb pulses 1 clk at the 8th rising edge with wr_addr=pointer, wr_data=byte.
//             Then WDATA_ACK and pointer auto-increments, wrapping NUM_REGS-1 -> 0.
//   WDATA_ACK drive 0, then WDATA (unbounded burst).
//   RDATA     drive shifter MSB first: sda_oe = ~bit. After 8 bits release SDA -> RACK; pointer increments with the same wrap.
//   RACK      sample master bit on SCL rise. 0 (ACK) -> reload shifter from regs[pointer], RDATA.
//             1 (NACK) -> IGNORE, busy=0.
//  A read without a preceding REG phase starts at the current pointer (set by the last write or read).
//  Bit counter is 3 bits, counts 7..0; the byte completes on the SCL rise where counter==0.
//  START/STOP in the middle of a byte discards the partial byte; a partial write byte is never committed, wr_stb does not pulse.
//  A START/STOP edge coincident with an SCL edge in the same clk gives condition detection priority.
//  Never drives SDA while SCL is high except a held ACK/data bit set on the preceding fall.
// TESTING
//  1 Write addr 0x50+W, reg 0x03, data 0xA5 -> 3 ACKs; wr_stb once with wr_addr=3, wr_data=0xA5; busy falls at STOP.
//  2 Burst write reg 0x0E with 0x11,0x22,0x33 (NUM_REGS=16) -> regs[14]=0x11, [15]=0x22, [0]=0x33 (wrap); 3 wr_stb pulses.
//  3 Write reg 0x02, repeated START, 0x50+R, read 3 bytes ACK,ACK,NACK -> regs[2..4] returned MSB-first; SDA released after NACK.
//  4 Address 0x51 -> no ACK (SDA stays high at the 9th clock); busy=0; next valid START to 0x50 is ACKed.
//  5 Reg 0x20 with NUM_REGS=16 -> NACK on the reg byte; following data bytes produce no wr_stb and no register change.
//  6 Assert rst mid-read while driving 0 -> sda_oe=0 next clk; STOP mid-byte during WDATA -> no wr_stb, register unchanged.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal byte register file.
// SCL/SDA are synchronised into the clk domain and oversampled, and are never used as clocks.
// Supports multi-byte bursts with pointer auto-increment and wrap, repeated START,
// NACK of a foreign device address or an out-of-range register index, and a write-notify strobe.
//
// wr_stb/wr_addr/wr_data handshake: wr_stb is a valid-only strobe with no ready. It is high for
// exactly one clk per committed byte, and wr_addr/wr_data are meaningful only in that clk.
// The consumer must take the byte in that cycle; there is no back-pressure.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [3:0] dbg_state
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] LAST_PTR   = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic [7:0] regs_q [NUM_REGS];

  logic             scl_s;
  logic             sda_s;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic [7:0]       byte_d;
  logic [2:0]       cnt_d;
  logic [7:0]       ptr_next_d;
  logic [IDX_W-1:0] rd_idx;
  logic             in_range;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  // Conditions only look at the current SCL level so a coincident SCL edge cannot mask them.
  assign start_det  = scl_s & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & ~sda_prev_q & sda_s;
  assign byte_d     = {shift_q[6:0], sda_s};
  assign cnt_d      = cnt_q - 3'd1;
  assign ptr_next_d = (ptr_q == LAST_PTR) ? 8'd0 : ptr_q + 8'd1;
  assign rd_idx     = ptr_q[IDX_W-1:0];
  assign in_range   = ({1'b0, byte_d} < NUM_REGS_W);
  assign dbg_state  = state_q;

  // Synchronisers plus one history flop per line; all load 1 so reset looks like an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Protocol FSM, register file and registered outputs.
  // Bits are taken on SCL rise; sda_oe is only updated on SCL fall, so SDA never moves while SCL is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd7;
      shift_q <= 8'd0;
      ptr_q   <= 8'd0;
      rw_q    <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        // START or repeated START: any partial byte is dropped.
        state_q <= S_ADDR;
        cnt_q   <= 3'd7;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state_q <= S_IDLE;
        cnt_q   <= 3'd7;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sda_oe <= 1'b0;
          end
          S_ADDR: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_d;
              if (cnt_q == 3'd0) begin
                if (byte_d[7:1] == SLAVE_ADDR) begin
                  state_q <= S_ADDR_ACK;
                  rw_q    <= byte_d[0];
                  busy    <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                  busy    <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) sda_oe <= 1'b1;
            if (scl_rise) begin
              cnt_q <= 3'd7;
              if (rw_q) begin
                shift_q <= regs_q[rd_idx];
                state_q <= S_RDATA;
              end else begin
                state_q <= S_REG;
              end
            end
          end
          S_REG: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_d;
              if (cnt_q == 3'd0) begin
                if (in_range) begin
                  ptr_q   <= byte_d;
                  state_q <= S_REG_ACK;
                end else begin
                  // Leaving SDA released during the ACK slot is the NACK.
                  state_q <= S_IGNORE;
                  busy    <= 1'b0;
                end
              end
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (scl_fall) sda_oe <= 1'b1;
            if (scl_rise) begin
              cnt_q   <= 3'd7;
              state_q <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_d;
              if (cnt_q == 3'd0) begin
                regs_q[rd_idx] <= byte_d;
                wr_stb         <= 1'b1;
                wr_addr        <= ptr_q;
                wr_data        <= byte_d;
                ptr_q          <= ptr_next_d;
                state_q        <= S_WDATA_ACK;
              end
            end
          end
          S_RDATA: begin
            if (scl_fall) sda_oe <= ~shift_q[7];
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], 1'b0};
              cnt_q   <= cnt_d;
              if (cnt_q == 3'd0) begin
                ptr_q   <= ptr_next_d;
                state_q <= S_RACK;
              end
            end
          end
          S_RACK: begin
            if (scl_fall) sda_oe <= 1'b0;
            if (scl_rise) begin
              if (!sda_s) begin
                shift_q <= regs_q[rd_idx];
                cnt_q   <= 3'd7;
                state_q <= S_RDATA;
              end else begin
                state_q <= S_IGNORE;
                busy    <= 1'b0;
              end
            end
          end
          S_IGNORE: begin
            if (scl_fall) sda_oe <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
